// File: rtl/ps2_pkg.sv
// Shared scan-code, modifier-flag and ASCII constants for the PS/2 keycode path.
package ps2_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned SK_W   = 3;

  // special_key bit positions
  localparam int unsigned SK_CTRL  = 2;
  localparam int unsigned SK_SHIFT = 1;
  localparam int unsigned SK_ALT   = 0;

  // Modifier scan codes (set 2, make codes)
  localparam logic [CODE_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [CODE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [CODE_W-1:0] SC_CTRL   = 8'h14;
  localparam logic [CODE_W-1:0] SC_ALT    = 8'h11;

  // Control-key scan codes
  localparam logic [CODE_W-1:0] SC_SPACE = 8'h29;
  localparam logic [CODE_W-1:0] SC_ENTER = 8'h5A;
  localparam logic [CODE_W-1:0] SC_BKSP  = 8'h66;
  localparam logic [CODE_W-1:0] SC_TAB   = 8'h0D;
  localparam logic [CODE_W-1:0] SC_ESC   = 8'h76;

  // ASCII control characters
  localparam logic [CODE_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [CODE_W-1:0] ASCII_LF    = 8'h0A;
  localparam logic [CODE_W-1:0] ASCII_BS    = 8'h08;
  localparam logic [CODE_W-1:0] ASCII_TAB   = 8'h09;
  localparam logic [CODE_W-1:0] ASCII_ESC   = 8'h1B;

  // Letter shift: uppercase sits 0x20 below lowercase
  function automatic logic [CODE_W-1:0] letter(input logic [CODE_W-1:0] lower,
                                               input logic shift);
    return shift ? CODE_W'(lower - 8'h20) : lower;
  endfunction

  // Pick the shifted or unshifted glyph of a two-symbol key
  function automatic logic [CODE_W-1:0] pick(input logic [CODE_W-1:0] lo,
                                             input logic [CODE_W-1:0] hi,
                                             input logic shift);
    return shift ? hi : lo;
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational scan-code-set-2 to ASCII table. Keypad entries built only
// when KEYPAD_EN is defined.
module ps2_ascii_rom
  import ps2_pkg::*;
#(
  parameter logic [CODE_W-1:0] UNKNOWN_CODE = 8'h00
) (
  input  logic [CODE_W-1:0] device_code,
  input  logic              shift,
  output logic [CODE_W-1:0] char_c
);

  // Table lookup; anything not listed maps to UNKNOWN_CODE
  always_comb begin
    char_c = UNKNOWN_CODE;
    case (device_code)
      // letters
      8'h1C: char_c = letter(8'h61, shift);
      8'h32: char_c = letter(8'h62, shift);
      8'h21: char_c = letter(8'h63, shift);
      8'h23: char_c = letter(8'h64, shift);
      8'h24: char_c = letter(8'h65, shift);
      8'h2B: char_c = letter(8'h66, shift);
      8'h34: char_c = letter(8'h67, shift);
      8'h33: char_c = letter(8'h68, shift);
      8'h43: char_c = letter(8'h69, shift);
      8'h3B: char_c = letter(8'h6A, shift);
      8'h42: char_c = letter(8'h6B, shift);
      8'h4B: char_c = letter(8'h6C, shift);
      8'h3A: char_c = letter(8'h6D, shift);
      8'h31: char_c = letter(8'h6E, shift);
      8'h44: char_c = letter(8'h6F, shift);
      8'h4D: char_c = letter(8'h70, shift);
      8'h15: char_c = letter(8'h71, shift);
      8'h2D: char_c = letter(8'h72, shift);
      8'h1B: char_c = letter(8'h73, shift);
      8'h2C: char_c = letter(8'h74, shift);
      8'h3C: char_c = letter(8'h75, shift);
      8'h2A: char_c = letter(8'h76, shift);
      8'h1D: char_c = letter(8'h77, shift);
      8'h22: char_c = letter(8'h78, shift);
      8'h35: char_c = letter(8'h79, shift);
      8'h1A: char_c = letter(8'h7A, shift);
      // digit row
      8'h45: char_c = pick(8'h30, 8'h29, shift);
      8'h16: char_c = pick(8'h31, 8'h21, shift);
      8'h1E: char_c = pick(8'h32, 8'h40, shift);
      8'h26: char_c = pick(8'h33, 8'h23, shift);
      8'h25: char_c = pick(8'h34, 8'h24, shift);
      8'h2E: char_c = pick(8'h35, 8'h25, shift);
      8'h36: char_c = pick(8'h36, 8'h5E, shift);
      8'h3D: char_c = pick(8'h37, 8'h26, shift);
      8'h3E: char_c = pick(8'h38, 8'h2A, shift);
      8'h46: char_c = pick(8'h39, 8'h28, shift);
      // punctuation
      8'h0E: char_c = pick(8'h60, 8'h7E, shift);
      8'h4E: char_c = pick(8'h2D, 8'h5F, shift);
      8'h55: char_c = pick(8'h3D, 8'h2B, shift);
      8'h54: char_c = pick(8'h5B, 8'h7B, shift);
      8'h5B: char_c = pick(8'h5D, 8'h7D, shift);
      8'h5D: char_c = pick(8'h5C, 8'h7C, shift);
      8'h4C: char_c = pick(8'h3B, 8'h3A, shift);
      8'h52: char_c = pick(8'h27, 8'h22, shift);
      8'h41: char_c = pick(8'h2C, 8'h3C, shift);
      8'h49: char_c = pick(8'h2E, 8'h3E, shift);
      8'h4A: char_c = pick(8'h2F, 8'h3F, shift);
      // controls
      SC_SPACE: char_c = ASCII_SPACE;
      SC_ENTER: char_c = ASCII_LF;
      SC_BKSP:  char_c = ASCII_BS;
      SC_TAB:   char_c = ASCII_TAB;
      SC_ESC:   char_c = ASCII_ESC;
`ifdef KEYPAD_EN
      // numeric keypad
      8'h70: char_c = 8'h30;
      8'h69: char_c = 8'h31;
      8'h72: char_c = 8'h32;
      8'h7A: char_c = 8'h33;
      8'h6B: char_c = 8'h34;
      8'h73: char_c = 8'h35;
      8'h74: char_c = 8'h36;
      8'h6C: char_c = 8'h37;
      8'h75: char_c = 8'h38;
      8'h7D: char_c = 8'h39;
      8'h71: char_c = 8'h2E;
      8'h79: char_c = 8'h2B;
      8'h7B: char_c = 8'h2D;
      8'h7C: char_c = 8'h2A;
`endif
      default: char_c = UNKNOWN_CODE;
    endcase
  end

endmodule

// File: rtl/ps2_keycode_resolver.sv
// PS/2 set-2 scan code to character code with modifier flags, one-cycle
// registered latency. Optional macro KEYPAD_EN adds numeric keypad mapping.
module ps2_keycode_resolver
  import ps2_pkg::*;
#(
  parameter logic [CODE_W-1:0] UNKNOWN_CODE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] device_code,
  input  logic              shift_pressed,
  output logic [CODE_W-1:0] internal_code,
  output logic [SK_W-1:0]   special_key
);

  logic [CODE_W-1:0] char_c;
  logic [SK_W-1:0]   special_c;

  ps2_ascii_rom #(
    .UNKNOWN_CODE(UNKNOWN_CODE)
  ) u_rom (
    .device_code(device_code),
    .shift      (shift_pressed),
    .char_c     (char_c)
  );

  // Modifier decode, independent of shift state
  always_comb begin
    special_c = '0;
    case (device_code)
      SC_CTRL:              special_c[SK_CTRL]  = 1'b1;
      SC_LSHIFT, SC_RSHIFT: special_c[SK_SHIFT] = 1'b1;
      SC_ALT:               special_c[SK_ALT]   = 1'b1;
      default:              special_c = '0;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      internal_code <= '0;
      special_key   <= '0;
    end else begin
      internal_code <= char_c;
      special_key   <= special_c;
    end
  end

endmodule

// File: tb/tb_ps2_keycode_resolver.sv
// Self-checking bench for ps2_keycode_resolver: golden tables built from
// character strings, per-cycle compare, plus directed literal checks.
module tb_ps2_keycode_resolver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] device_code;
  logic       shift_pressed;
  logic [7:0] internal_code;
  logic [2:0] special_key;

  int checks   = 0;
  int failures = 0;

  ps2_keycode_resolver #(.UNKNOWN_CODE(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .device_code  (device_code),
    .shift_pressed(shift_pressed),
    .internal_code(internal_code),
    .special_key  (special_key)
  );

  always #5 clk = ~clk;

  // Golden tables indexed by scan code
  logic [7:0] gold_lo [256];
  logic [7:0] gold_hi [256];
  logic [2:0] gold_sk [256];

  task automatic build_tables();
    logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                   8'h3D, 8'h3E, 8'h46};
    logic [7:0] pun_codes [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C,
                                   8'h52, 8'h41, 8'h49, 8'h4A};
    logic [7:0] pun_lo [11]    = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B,
                                   8'h27, 8'h2C, 8'h2E, 8'h2F};
    logic [7:0] pun_hi [11]    = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A,
                                   8'h22, 8'h3C, 8'h3E, 8'h3F};
    logic [7:0] ctl_codes [5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] ctl_chars [5]  = '{8'h20, 8'h0A, 8'h08, 8'h09, 8'h1B};
    logic [7:0] kp_codes [14]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74,
                                   8'h6C, 8'h75, 8'h7D, 8'h71, 8'h79, 8'h7B, 8'h7C};
    string lower   = "abcdefghijklmnopqrstuvwxyz";
    string upper   = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string digs    = "0123456789";
    string dig_sh  = ")!@#$%^&*(";
    string kp_char = "0123456789.+-*";
    for (int i = 0; i < 256; i++) begin
      gold_lo[i] = 8'h00;
      gold_hi[i] = 8'h00;
      gold_sk[i] = 3'b000;
    end
    for (int i = 0; i < 26; i++) begin
      gold_lo[let_codes[i]] = 8'(lower[i]);
      gold_hi[let_codes[i]] = 8'(upper[i]);
    end
    for (int i = 0; i < 10; i++) begin
      gold_lo[dig_codes[i]] = 8'(digs[i]);
      gold_hi[dig_codes[i]] = 8'(dig_sh[i]);
    end
    for (int i = 0; i < 11; i++) begin
      gold_lo[pun_codes[i]] = pun_lo[i];
      gold_hi[pun_codes[i]] = pun_hi[i];
    end
    for (int i = 0; i < 5; i++) begin
      gold_lo[ctl_codes[i]] = ctl_chars[i];
      gold_hi[ctl_codes[i]] = ctl_chars[i];
    end
`ifdef KEYPAD_EN
    for (int i = 0; i < 14; i++) begin
      gold_lo[kp_codes[i]] = 8'(kp_char[i]);
      gold_hi[kp_codes[i]] = 8'(kp_char[i]);
    end
`else
    if (kp_codes[0] == 8'hFF) $display("unused %s", kp_char);
`endif
    gold_sk[8'h14] = 3'b100;
    gold_sk[8'h12] = 3'b010;
    gold_sk[8'h59] = 3'b010;
    gold_sk[8'h11] = 3'b001;
  endtask

  // Expected outputs: what was sampled at the last rising edge
  logic [7:0] exp_ic, exp_code;
  logic [2:0] exp_sk;
  logic       exp_sh;
  bit         run_cmp = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_ic <= 8'h00;
      exp_sk <= 3'b000;
    end else begin
      exp_ic   <= shift_pressed ? gold_hi[device_code] : gold_lo[device_code];
      exp_sk   <= gold_sk[device_code];
      exp_code <= device_code;
      exp_sh   <= shift_pressed;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      checks++;
      if (internal_code !== exp_ic || special_key !== exp_sk) begin
        failures++;
        $display("FAIL model code=%h shift=%b: got ic=%h sk=%b, want ic=%h sk=%b",
                 exp_code, exp_sh, internal_code, special_key, exp_ic, exp_sk);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Drive inputs after a falling edge, then sample 1 time unit after the rising edge
  task automatic step(input logic [7:0] code, input logic sh);
    @(negedge clk);
    device_code   = code;
    shift_pressed = sh;
    @(posedge clk);
    #1;
  endtask

  initial begin
    build_tables();
    rst           = 1'b1;
    device_code   = 8'h1C;
    shift_pressed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ic", internal_code, 8'h00);
    check("reset_sk", 8'(special_key), 8'h00);
    run_cmp = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("a_after_reset", internal_code, 8'h61);

    step(8'h1C, 1'b1); check("A_shift", internal_code, 8'h41);
    step(8'h1C, 1'b0); check("a_unshift", internal_code, 8'h61);
    step(8'h16, 1'b0); check("digit1", internal_code, 8'h31);
    step(8'h16, 1'b1); check("bang", internal_code, 8'h21);
    step(8'h52, 1'b1); check("dquote", internal_code, 8'h22);
    step(8'h12, 1'b0); check("lshift_sk", 8'(special_key), 8'h02);
    check("lshift_ic", internal_code, 8'h00);
    step(8'h59, 1'b1); check("rshift_sk", 8'(special_key), 8'h02);
    step(8'h14, 1'b0); check("ctrl_sk", 8'(special_key), 8'h04);
    step(8'h11, 1'b1); check("alt_sk", 8'(special_key), 8'h01);
    step(8'h1C, 1'b0); check("letter_sk", 8'(special_key), 8'h00);
    step(8'h5A, 1'b0); check("enter_lo", internal_code, 8'h0A);
    step(8'h5A, 1'b1); check("enter_hi", internal_code, 8'h0A);
    step(8'h66, 1'b0); check("bksp_lo", internal_code, 8'h08);
    step(8'h66, 1'b1); check("bksp_hi", internal_code, 8'h08);
    step(8'hF0, 1'b0); check("f0_unknown", internal_code, 8'h00);
    step(8'h00, 1'b1); check("00_unknown", internal_code, 8'h00);
`ifdef KEYPAD_EN
    step(8'h70, 1'b0); check("kp0", internal_code, 8'h30);
`else
    step(8'h70, 1'b0); check("kp0_off", internal_code, 8'h00);
`endif

    // Asynchronous reset between clock edges
    step(8'h1C, 1'b1);
    check("pre_async", internal_code, 8'h41);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ic", internal_code, 8'h00);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Full sweep against the golden tables
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        device_code   = 8'(c);
        shift_pressed = s[0];
      end
    end
    @(negedge clk);
    @(negedge clk);
    run_cmp = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global timeout guard
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
